// File: rtl/chain_pkg.sv
// Shared types and constants for the chaining-DP max reduction.
// Optional early stop is enabled with the CHAIN_MAX_SKIP_EN macro.
package chain_pkg;

    localparam int CHAIN_SCORE_W = 32;
    localparam int CHAIN_IDX_W   = 16;

    typedef logic signed [CHAIN_SCORE_W-1:0] score_t;
    typedef logic [CHAIN_IDX_W-1:0]          idx_t;

    localparam idx_t   NO_PRED   = '1;
    localparam score_t SCORE_MAX = {1'b0, {(CHAIN_SCORE_W-1){1'b1}}};
    localparam score_t SCORE_MIN = {1'b1, {(CHAIN_SCORE_W-1){1'b0}}};

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] ACCUM = 2'd1;
    localparam logic [1:0] DONE  = 2'd2;

endpackage

// File: rtl/chain_sat_add.sv
// Combinational signed adder that clamps to the representable range.
// Part of chain_dp_max (CHAIN_MAX_SKIP_EN has no effect here).
module chain_sat_add
    import chain_pkg::*;
#(
    parameter int W = CHAIN_SCORE_W
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic [W-1:0] sum
);

    logic [W:0] wide;

    assign wide = {a[W-1], a} + {b[W-1], b};

    // Sign-extended sum disagrees in its top two bits only on overflow.
    always_comb begin
        sum = wide[W-1:0];
        if (wide[W] != wide[W-1])
            sum = wide[W] ? {1'b1, {(W-1){1'b0}}}
                          : {1'b0, {(W-1){1'b1}}};
    end

endmodule

// File: rtl/chain_dp_max.sv
// f(i) = max(qspan, max_j f(j)+sc(j,i)) and best predecessor p(i).
// Define CHAIN_MAX_SKIP_EN to stop comparing after MAX_SKIP misses.
module chain_dp_max
    import chain_pkg::*;
#(
    parameter int SCORE_W  = CHAIN_SCORE_W,
    parameter int IDX_W    = CHAIN_IDX_W,
    parameter int MAX_SKIP = 25
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start_valid,
    output logic               start_ready,
    input  logic [SCORE_W-1:0] start_qspan,
    input  logic               start_nopred,
    input  logic               cand_valid,
    output logic               cand_ready,
    input  logic [IDX_W-1:0]   cand_idx,
    input  logic [SCORE_W-1:0] cand_f,
    input  logic [SCORE_W-1:0] cand_sc,
    input  logic               cand_skip,
    input  logic               cand_last,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [SCORE_W-1:0] out_f,
    output logic [IDX_W-1:0]   out_p,
    output logic [IDX_W-1:0]   out_ncand
);

    localparam logic [IDX_W-1:0] NO_IDX = '1;

    if (MAX_SKIP < 1) begin : g_bad_cfg
        $error("MAX_SKIP must be at least 1");
    end

    logic [1:0]         state;
    logic [SCORE_W-1:0] best;
    logic [IDX_W-1:0]   bidx;
    logic [IDX_W-1:0]   ncand;
    logic [SCORE_W-1:0] sum;
    logic               cmp_en;
    logic               accept;
    logic               improve;

    chain_sat_add #(.W(SCORE_W)) u_add (
        .a   (cand_f),
        .b   (cand_sc),
        .sum (sum)
    );

    assign start_ready = (state == IDLE);
    assign cand_ready  = (state == ACCUM);
    assign out_valid   = (state == DONE);
    assign out_f       = best;
    assign out_p       = bidx;
    assign out_ncand   = ncand;

    assign accept  = cand_valid && cand_ready;
    assign improve = accept && !cand_skip && cmp_en
                     && ($signed(sum) > $signed(best));

`ifdef CHAIN_MAX_SKIP_EN
    localparam int SKIP_W = $clog2(MAX_SKIP + 1);

    logic [SKIP_W-1:0] skip_cnt;

    assign cmp_en = (skip_cnt < SKIP_W'(MAX_SKIP));

    // Skipped-window candidates neither extend nor break the miss run.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            skip_cnt <= '0;
        else if (start_valid && start_ready)
            skip_cnt <= '0;
        else if (accept && !cand_skip && cmp_en)
            skip_cnt <= improve ? '0 : skip_cnt + 1'b1;
    end
`else
    assign cmp_en = 1'b1;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
            best  <= '0;
            bidx  <= NO_IDX;
            ncand <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (start_valid) begin
                        best  <= start_qspan;
                        bidx  <= NO_IDX;
                        ncand <= '0;
                        state <= start_nopred ? DONE : ACCUM;
                    end
                end
                ACCUM: begin
                    if (accept) begin
                        if (improve) begin
                            best <= sum;
                            bidx <= cand_idx;
                        end
                        if (ncand != NO_IDX)
                            ncand <= ncand + 1'b1;
                        if (cand_last)
                            state <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready)
                        state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_chain_dp_max.sv
// Directed bench for chain_dp_max; expectations follow CHAIN_MAX_SKIP_EN.
module tb_chain_dp_max;
    import chain_pkg::*;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        start_valid = 1'b0;
    logic        start_ready;
    logic [31:0] start_qspan = '0;
    logic        start_nopred = 1'b0;
    logic        cand_valid = 1'b0;
    logic        cand_ready;
    logic [15:0] cand_idx = '0;
    logic [31:0] cand_f = '0;
    logic [31:0] cand_sc = '0;
    logic        cand_skip = 1'b0;
    logic        cand_last = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out_f;
    logic [15:0] out_p;
    logic [15:0] out_ncand;

    int n_checks = 0;
    int n_fail   = 0;

    chain_dp_max #(.SCORE_W(32), .IDX_W(16), .MAX_SKIP(2)) dut (
        .clk          (clk),
        .reset        (reset),
        .start_valid  (start_valid),
        .start_ready  (start_ready),
        .start_qspan  (start_qspan),
        .start_nopred (start_nopred),
        .cand_valid   (cand_valid),
        .cand_ready   (cand_ready),
        .cand_idx     (cand_idx),
        .cand_f       (cand_f),
        .cand_sc      (cand_sc),
        .cand_skip    (cand_skip),
        .cand_last    (cand_last),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_f        (out_f),
        .out_p        (out_p),
        .out_ncand    (out_ncand)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag,
                         input logic [63:0] obs,
                         input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic do_start(input logic [31:0] qspan, input logic nopred);
        @(negedge clk);
        start_valid  = 1'b1;
        start_qspan  = qspan;
        start_nopred = nopred;
        @(posedge clk);
        #1;
        start_valid  = 1'b0;
        start_nopred = 1'b0;
    endtask

    task automatic send(input logic [15:0] j, input logic [31:0] f,
                        input logic [31:0] sc, input logic skip,
                        input logic last);
        @(negedge clk);
        cand_valid = 1'b1;
        cand_idx   = j;
        cand_f     = f;
        cand_sc    = sc;
        cand_skip  = skip;
        cand_last  = last;
        @(posedge clk);
        #1;
        cand_valid = 1'b0;
        cand_skip  = 1'b0;
        cand_last  = 1'b0;
    endtask

    task automatic expect_out(input string tag, input logic [31:0] f,
                              input logic [15:0] p, input logic [15:0] n);
        check({tag, ".valid"}, 64'(out_valid), 64'd1);
        check({tag, ".f"}, 64'(out_f), 64'(f));
        check({tag, ".p"}, 64'(out_p), 64'(p));
        check({tag, ".ncand"}, 64'(out_ncand), 64'(n));
    endtask

    task automatic drain(input string tag);
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        check({tag, ".idle"}, 64'(start_ready), 64'd1);
        check({tag, ".vld0"}, 64'(out_valid), 64'd0);
    endtask

    initial begin
        #12;
        check("rst.valid", 64'(out_valid), 64'd0);
        check("rst.f", 64'(out_f), 64'd0);
        check("rst.p", 64'(out_p), 64'hFFFF);
        check("rst.ncand", 64'(out_ncand), 64'd0);
        check("rst.sready", 64'(start_ready), 64'd1);
        check("rst.cready", 64'(cand_ready), 64'd0);
        reset = 1'b1;

        // Candidate while idle must be ignored.
        send(16'd3, 32'd999, 32'd0, 1'b0, 1'b1);
        check("idle.cand", 64'(cand_ready), 64'd0);
        do_start(32'd15, 1'b1);
        expect_out("t1", 32'd15, 16'hFFFF, 16'd0);
        drain("t1");

        do_start(32'd15, 1'b0);
        check("t2.cready", 64'(cand_ready), 64'd1);
        send(16'd9, 32'd40, -32'sd5, 1'b0, 1'b0);
        check("t2.mid", 64'(out_valid), 64'd0);
        send(16'd8, 32'd30, 32'd10, 1'b0, 1'b1);
        expect_out("t2", 32'd40, 16'd8, 16'd2);
        drain("t2");

        do_start(32'd0, 1'b0);
        send(16'd5, 32'd20, 32'd5, 1'b0, 1'b0);
        send(16'd4, 32'd30, -32'sd5, 1'b0, 1'b1);
        expect_out("tie", 32'd25, 16'd5, 16'd2);
        drain("tie");

        do_start(32'd0, 1'b0);
        send(16'd7, 32'h7FFFFFF0, 32'd100, 1'b0, 1'b1);
        expect_out("sat", 32'h7FFFFFFF, 16'd7, 16'd1);
        drain("sat");

        do_start(32'd0, 1'b0);
        send(16'd3, 32'd1000, 32'd0, 1'b1, 1'b0);
        send(16'd2, 32'd10, 32'd5, 1'b0, 1'b1);
        expect_out("skip", 32'd15, 16'd2, 16'd2);
        drain("skip");

        do_start(32'd7, 1'b0);
        send(16'd1, 32'd3, 32'd10, 1'b0, 1'b1);
        @(negedge clk);
        start_valid = 1'b1;
        start_qspan = 32'd500;
        cand_valid  = 1'b1;
        cand_f      = 32'd900;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            check("stall.sready", 64'(start_ready), 64'd0);
            check("stall.cready", 64'(cand_ready), 64'd0);
            check("stall.f", 64'(out_f), 64'd13);
        end
        start_valid = 1'b0;
        cand_valid  = 1'b0;
        expect_out("stall", 32'd13, 16'd1, 16'd1);
        drain("stall");

        do_start(32'd5, 1'b0);
        send(16'd2, 32'd100, 32'd0, 1'b0, 1'b0);
        @(negedge clk);
        reset = 1'b0;
        #1;
        check("arst.valid", 64'(out_valid), 64'd0);
        check("arst.sready", 64'(start_ready), 64'd1);
        check("arst.cready", 64'(cand_ready), 64'd0);
        check("arst.p", 64'(out_p), 64'hFFFF);
        @(negedge clk);
        reset = 1'b1;

        do_start(32'd0, 1'b0);
        send(16'd9, 32'd50, 32'd0, 1'b0, 1'b0);
        send(16'd8, 32'd10, 32'd0, 1'b0, 1'b0);
        send(16'd7, 32'd10, 32'd0, 1'b0, 1'b0);
        send(16'd6, 32'd100, 32'd0, 1'b0, 1'b1);
`ifdef CHAIN_MAX_SKIP_EN
        expect_out("maxskip", 32'd50, 16'd9, 16'd4);
`else
        expect_out("maxskip", 32'd100, 16'd6, 16'd4);
`endif
        drain("maxskip");

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
